sobel_stream: RTL and testbench

Parametrised streaming Sobel edge-magnitude stage for the image pipeline. Reads grayscale pixels in raster order from an upstream first-word-fall-through FIFO and writes one edge-magnitude pixel per input pixel to a downstream FIFO. It generalises the fixed 8-bit, 720x540 Sobel stage to arbitrary frame size and pixel width, and adds an optional binary threshold mode. Frames run back-to-back with no gap or reconfiguration.

---
 rtl/sobel_pkg.sv | 46 ++++
 rtl/sobel_window.sv | 42 ++++
 rtl/sobel_stream.sv | 131 +++++++++++++
 tb/tb_sobel_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and arithmetic for the streaming Sobel stage.
// Holds the window sizing rule and the saturated edge-magnitude function.
package sobel_pkg;

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  // Widest supported pixel; the magnitude math is sized for this.
  localparam int MAX_PW = 16;

  typedef logic [MAX_PW+2:0]        wide_t;
  typedef logic signed [MAX_PW+2:0] swide_t;

  // Two full rows plus three pixels hold every tap of a 3x3 window.
  function automatic int sobel_reg_size(input int img_width);
    return 2 * img_width + 3;
  endfunction

  function automatic swide_t sext(input logic [MAX_PW-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Window order: 0..2 top row, 3..5 middle row, 6..8 bottom row, left to right.
  function automatic logic [MAX_PW-1:0] sobel_mag(input logic [MAX_PW-1:0] win [9],
                                                  input int pw);
    swide_t gx;
    swide_t gy;
    wide_t  ax;
    wide_t  ay;
    wide_t  sum;
    wide_t  lim;
    gx  = (sext(win[2]) + (sext(win[5]) <<< 1) + sext(win[8]))
        - (sext(win[0]) + (sext(win[3]) <<< 1) + sext(win[6]));
    gy  = (sext(win[6]) + (sext(win[7]) <<< 1) + sext(win[8]))
        - (sext(win[0]) + (sext(win[1]) <<< 1) + sext(win[2]));
    ax  = (gx < 0) ? $unsigned(-gx) : $unsigned(gx);
    ay  = (gy < 0) ? $unsigned(-gy) : $unsigned(gy);
    sum = (ax + ay) >> 1;
    lim = wide_t'((1 << pw) - 1);
    return (sum > lim) ? lim[MAX_PW-1:0] : sum[MAX_PW-1:0];
  endfunction

endpackage

// File: rtl/sobel_window.sv
// Raster-order pixel delay line feeding a 3x3 window; taps show the window as it
// will be after the current shift, so the incoming pixel is the newest tap.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH   = 720,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic [PIXEL_WIDTH-1:0] din,
  output logic [PIXEL_WIDTH-1:0] taps [9]
);

  // The incoming pixel is the youngest window element, so one stage less is stored.
  localparam int DEPTH = sobel_reg_size(IMG_WIDTH) - 1;

  logic [PIXEL_WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (shift_en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  always_comb begin
    taps[0] = sr[2*IMG_WIDTH+1];
    taps[1] = sr[2*IMG_WIDTH];
    taps[2] = sr[2*IMG_WIDTH-1];
    taps[3] = sr[IMG_WIDTH+1];
    taps[4] = sr[IMG_WIDTH];
    taps[5] = sr[IMG_WIDTH-1];
    taps[6] = sr[1];
    taps[7] = sr[0];
    taps[8] = din;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming Sobel edge magnitude, one output per input pixel in raster order; the output
// for centre k is registered when pixel k+W+1 is accepted. A full output FIFO freezes everything.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH   = 720,
  parameter int IMG_HEIGHT  = 540,
  parameter int PIXEL_WIDTH = 8,
  parameter int THRESH_EN   = 0,
  parameter int THRESHOLD   = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  input  logic [PIXEL_WIDTH-1:0] in_dout,
  input  logic                   out_full,
  output logic                   out_wr_en,
  output logic [PIXEL_WIDTH-1:0] out_din
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 1);

  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0]     COL_PEN   = CW'(IMG_WIDTH - 2);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0]     ROW_PEN   = RW'(IMG_HEIGHT - 2);
  localparam logic [FW-1:0]     FILL_LAST = FW'(IMG_WIDTH);
  localparam logic [MAX_PW-1:0] THRESH_V  = MAX_PW'(THRESHOLD);

  state_t                 state_q;
  state_t                 state_d;
  logic [RW-1:0]          row_q;
  logic [CW-1:0]          col_q;
  logic [FW-1:0]          fill_q;
  logic                   out_valid;
  logic [PIXEL_WIDTH-1:0] out_data;

  logic                   adv;
  logic                   shift;
  logic                   emit;
  logic                   at_last;
  logic                   border;
  logic [PIXEL_WIDTH-1:0] win_din;
  logic [PIXEL_WIDTH-1:0] taps [9];
  logic [MAX_PW-1:0]      win  [9];
  logic [MAX_PW-1:0]      mag_full;
  logic [PIXEL_WIDTH-1:0] pix;

  sobel_window #(
    .IMG_WIDTH  (IMG_WIDTH),
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_window (
    .clock   (clock),
    .reset   (reset),
    .shift_en(shift),
    .din     (win_din),
    .taps    (taps)
  );

  // Row/col track the centre of the window being emitted, not the input pixel.
  assign at_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign border  = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);

  always_comb begin
    state_d  = state_q;
    adv      = ~out_valid | ~out_full;
    in_rd_en = reset && (state_q != S_FLUSH) && adv && !in_empty;
    shift    = (state_q == S_FLUSH) ? adv : in_rd_en;
    emit     = shift && (state_q != S_FILL);
    win_din  = (state_q == S_FLUSH) ? '0 : in_dout;
    case (state_q)
      S_FILL:  if (shift && fill_q == FILL_LAST) state_d = S_RUN;
      S_RUN:   if (shift && row_q == ROW_PEN && col_q == COL_PEN) state_d = S_FLUSH;
      S_FLUSH: if (shift && at_last) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 9; i++) win[i] = MAX_PW'(taps[i]);
    mag_full = sobel_mag(win, PIXEL_WIDTH);
    if (border) begin
      pix = '0;
    end else if (THRESH_EN != 0) begin
      pix = (mag_full >= THRESH_V) ? '1 : '0;
    end else begin
      pix = mag_full[PIXEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FILL;
      fill_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      if (shift && state_q == S_FILL) begin
        fill_q <= (fill_q == FILL_LAST) ? '0 : fill_q + FW'(1);
      end
      if (emit) begin
        if (at_last) begin
          row_q <= '0;
          col_q <= '0;
        end else if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      // A held word stays valid until the downstream FIFO takes it.
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= pix;
      end else if (!out_full) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_wr_en = out_valid & ~out_full;
  assign out_din   = out_data;

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream on an 8x4 frame: plain and thresholded instances, queued
// expectations checked by per-instance monitors on every downstream write.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 4;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int img  [H][W];
  int hand [H][W];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int model(input int r, input int c, input int thr);
    int gx, gy, m;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (gx + gy) / 2;
    if (m > 255) m = 255;
    if (thr != 0) return (m >= 64) ? 255 : 0;
    return m;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_ch
    logic       in_empty, in_rd_en, out_full, out_wr_en;
    logic [7:0] in_dout, out_din;
    logic [7:0] src_q [$];
    logic [7:0] exp_q [$];
    bit         gap_en = 0;
    bit         chk_flush_rd = 0;
    int         wr_count = 0, rd_count = 0, pushed = 0, t0 = 0, t1 = 0;

    sobel_stream #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .THRESH_EN(d), .THRESHOLD(64)
    ) dut (
      .clock(clock), .reset(reset),
      .in_empty(in_empty), .in_rd_en(in_rd_en), .in_dout(in_dout),
      .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din)
    );

    // Upstream FWFT FIFO model: pops what the DUT read on the previous rising edge.
    initial begin : drv
      bit pop;
      pop      = 0;
      in_empty = 1'b1;
      in_dout  = 8'h00;
      forever begin
        @(negedge clock);
        if (pop && src_q.size() > 0) begin
          if (rd_count == 0) t0 = cyc;
          if (rd_count == W*H) t1 = cyc;
          rd_count++;
          void'(src_q.pop_front());
        end
        in_empty = (src_q.size() == 0) || (gap_en && $urandom_range(0, 1) == 1);
        in_dout  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        #1 pop = in_rd_en;
      end
    end

    initial begin : mon
      logic [7:0] e;
      forever begin
        @(negedge clock);
        #2;
        if (out_wr_en === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ch%0d unexpected_write: got %0d expected no write", d, out_din);
          end else begin
            e = exp_q.pop_front();
            if (out_din !== e) begin
              n_fail++;
              $display("FAIL ch%0d pixel %0d: got %0d expected %0d", d, wr_count, out_din, e);
            end
            if (chk_flush_rd && exp_q.size() <= W) chk("flush_rd_en_low", int'(in_rd_en), 0);
          end
          wr_count++;
        end
      end
    end

    task automatic load(input bit use_model);
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          src_q.push_back(8'(img[r][c]));
          exp_q.push_back(8'(use_model ? model(r, c, d) : hand[r][c]));
          pushed++;
        end
      end
    endtask

    task automatic drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
        @(negedge clock);
        n++;
      end
      repeat (W + 6) @(negedge clock);
      chk({nm, "_remaining"}, exp_q.size(), 0);
      chk({nm, "_writes"}, wr_count, pushed);
    endtask
  end

  task automatic fill_step();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c]  = (c >= 4) ? 255 : 0;
        hand[r][c] = (r >= 1 && r <= 2 && (c == 3 || c == 4)) ? 255 : 0;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [7:0] held;
    reset = 1'b0;
    g_ch[0].out_full = 1'b0;
    g_ch[1].out_full = 1'b0;
    repeat (3) @(negedge clock);
    #3;
    chk("reset_rd_en", int'(g_ch[0].in_rd_en), 0);
    chk("reset_wr_en", int'(g_ch[0].out_wr_en), 0);
    chk("reset_din", int'(g_ch[0].out_din), 0);
    chk("reset_thr_din", int'(g_ch[1].out_din), 0);
    @(negedge clock);
    reset = 1'b1;

    // Flat image: every gradient is zero; the last W+1 writes come from the flush.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c]  = 100;
        hand[r][c] = 0;
      end
    g_ch[0].chk_flush_rd = 1;
    g_ch[0].load(0);
    g_ch[0].drain("constant");
    g_ch[0].chk_flush_rd = 0;

    fill_step();
    g_ch[0].load(0);
    g_ch[0].drain("step");

    // Same step frame with a 5-cycle downstream stall in row 1.
    fill_step();
    g_ch[0].load(0);
    n = g_ch[0].wr_count;
    while (g_ch[0].wr_count < n + 10 && cyc < 100000) begin
      @(negedge clock);
      #3;
    end
    @(negedge clock);
    g_ch[0].out_full = 1'b1;
    #3 held = g_ch[0].out_din;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rd_en", int'(g_ch[0].in_rd_en), 0);
      chk("stall_wr_en", int'(g_ch[0].out_wr_en), 0);
      chk("stall_din_hold", int'(g_ch[0].out_din), int'(held));
      @(negedge clock);
      #3;
    end
    @(negedge clock);
    g_ch[0].out_full = 1'b0;
    g_ch[0].drain("stall");

    g_ch[0].gap_en = 1;
    fill_random();
    g_ch[0].load(1);
    g_ch[0].drain("gaps");
    g_ch[0].gap_en = 0;

    // Thresholded ramps: step 16 gives magnitude 64 (hit), step 15 gives 60 (miss).
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c]  = 16 * c;
        hand[r][c] = (r >= 1 && r <= H-2 && c >= 1 && c <= W-2) ? 255 : 0;
      end
    g_ch[1].load(0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c]  = 15 * c;
        hand[r][c] = 0;
      end
    g_ch[1].load(0);
    g_ch[1].drain("thresh");

    // Abort a frame with reset once interior outputs are flowing.
    fill_random();
    g_ch[0].load(1);
    repeat (22) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("midreset_rd_en", int'(g_ch[0].in_rd_en), 0);
      chk("midreset_wr_en", int'(g_ch[0].out_wr_en), 0);
      chk("midreset_din", int'(g_ch[0].out_din), 0);
      @(negedge clock);
    end
    #3;
    g_ch[0].src_q.delete();
    g_ch[0].exp_q.delete();
    g_ch[0].wr_count = 0;
    g_ch[0].pushed   = 0;
    g_ch[0].rd_count = 0;
    @(negedge clock);
    reset = 1'b1;
    fill_random();
    g_ch[0].load(1);
    fill_random();
    g_ch[0].load(1);
    g_ch[0].drain("b2b");
    chk("b2b_frame_gap_cycles", g_ch[0].t1 - g_ch[0].t0, W*H + W + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
